uart_word_sender: RTL
=====================

Name: uart_word_sender

Overview:
- Transmit end of the core's UART link. It is the counterpart of receiver_wrapper, which assembles incoming RX bytes into 32-bit words for OP_IN.
- Accepts one 32-bit word or a single byte from the core's OP_OUT path through a valid/ready handshake.
- Serialises the data onto UART_TX as 8N1 frames, LSB-first bit order, low byte first.
- Single-entry, unbuffered. Sits between the core's output registers and the board TX pin.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200). Must be >= 2.
- CNT_WIDTH, 10, width of the baud counter. Must satisfy 2^CNT_WIDTH > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock (clk_wiz output); all logic is on its rising edge.
- rst  input  1  synchronous reset, active-high.
- valid  input  1  request to send; sampled together with data and id.
- ready  output  1  high when idle and able to accept; transfer occurs on valid&&ready at a rising edge.
- data  input  32  payload; captured on transfer.
- id  input  1  0 = send data[7:0] only (1 byte); 1 = send all 4 bytes, data[7:0] first and data[31:24] last.
- done  output  1  one-cycle pulse in the cycle after the last stop bit of the transfer completes.
- UART_TX  output  1  serial line, idle high, registered.

Behaviour:
- Reset (rst=1 at an edge), effective the next cycle:
  - UART_TX=1, ready=1, done=0.
  - State=IDLE; baud counter, bit counter and byte index cleared.
  - A frame in progress is aborted; the truncated frame is accepted. rst overrides every other input.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - ready=1, UART_TX=1.
  - On valid&&ready: latch data into a 32-bit shift register and latch id into a byte count (id=0 gives 1 byte, id=1 gives 4).
  - Next cycle: ready=0, state=START, UART_TX=0.
  - Latency from accepting edge to start-bit edge is exactly 1 cycle.
- START: UART_TX=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - 8 bits, each held exactly CLKS_PER_BIT cycles.
  - Bit order is shift[0] first. The 8-bit shift register shifts right one place per bit.
- STOP: UART_TX=1 for exactly CLKS_PER_BIT cycles. Then:
  - If bytes remain: shift the word right 8, decrement the remaining count, go to START with no idle gap. The next start bit begins on the cycle after the stop bit ends.
  - Else: go to IDLE, ready=1, done=1 for one cycle.
- Timing:
  - 1-byte transfer: ready low for 10*CLKS_PER_BIT cycles.
  - 4-byte transfer: ready low for 40*CLKS_PER_BIT cycles.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Reset to 0 on acceptance so the first bit is full length.
- Handshake:
  - valid while ready=0 is ignored; there is no queue, and the core must hold valid until ready.
  - data and id may change freely after the transfer edge.
  - A new transfer may be accepted in the same cycle that done=1 and ready=1. This gives back-to-back frames with exactly one idle-high cycle between words.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan (CLKS_PER_BIT=4):
- Reset: hold rst 3 cycles, then release. Required: UART_TX=1, ready=1, done=0 throughout; UART_TX stays 1 for 20 cycles with valid=0.
- Single byte: id=0, data=0x000000A5, valid for 1 cycle.
  - UART_TX sampled at mid-bit reads 0,1,0,1,0,0,1,0,1,1.
  - ready=0 for 40 cycles, then ready=1 with done pulsed once.
- Word: id=1, data=0x12345678.
  - Four contiguous frames carrying bytes 0x78, 0x56, 0x34, 0x12, with no idle bits between frames.
  - ready=0 for 160 cycles; exactly one done pulse, at the end.
- Busy ignore: during the 0x12345678 word, pulse valid with data=0xFFFFFFFF. Required: the line output is unchanged, and no extra frame is sent afterwards.
- Back-to-back: hold valid=1 with id=0, data=0x3C, across the done cycle. Required: the second frame's start bit begins 1 cycle after the first frame's stop bit ends; two done pulses 41 cycles apart.
- Reset mid-frame: assert rst during the DATA bits of 0x12345678. Required: the next cycle UART_TX=1 and ready=1; no done pulse; a new transfer of 0x55 (id=0) then completes normally.

Source files
------------

// File: rtl/uart_word_sender_if.sv
// Core-side handshake bundle for the UART word sender: the request (valid/data/id)
// and its status returns (ready/done).
interface uart_word_sender_if;
    logic        valid;
    logic        ready;
    logic [31:0] data;
    logic        id;
    logic        done;

    modport master (
        output valid,
        output data,
        output id,
        input  ready,
        input  done
    );

    modport slave (
        input  valid,
        input  data,
        input  id,
        output ready,
        output done
    );
endinterface

// File: rtl/uart_word_sender.sv
// UART transmit end of the core link: sends one byte or a 32-bit word (low byte first)
// as back-to-back 8N1 frames, LSB first, with a one-cycle done pulse at the end.
module uart_word_sender #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_WIDTH    = 10
) (
    input  logic              clk,
    input  logic              rst,
    uart_word_sender_if.slave bus,
    output logic              UART_TX
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] BAUD_LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] baud_q, baud_d;
    logic [2:0]           bit_q, bit_d;
    logic [1:0]           bytes_q, bytes_d;
    logic [31:0]          word_q, word_d;
    logic [7:0]           shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic                 bit_end_s;

    assign bit_end_s = (baud_q == BAUD_LAST);

    // Next-state and registered-output computation for the framing FSM.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        bytes_d = bytes_q;
        word_d  = word_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                if (bus.valid && ready_q) begin
                    word_d  = bus.data;
                    bytes_d = bus.id ? 2'd3 : 2'd0;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    state_d = START;
                end else begin
                    baud_d = '0;
                end
            end
            START: begin
                if (bit_end_s) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    shift_d = word_q[7:0];
                    tx_d    = word_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + CNT_WIDTH'(1);
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        // Rotate rather than shift so the register's low bit stays live.
                        bit_d   = bit_q + 3'd1;
                        shift_d = {shift_q[0], shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + CNT_WIDTH'(1);
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    baud_d = '0;
                    if (bytes_q != 2'd0) begin
                        word_d  = {8'h00, word_q[31:8]};
                        bytes_d = bytes_q - 2'd1;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                baud_d  = '0;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame and returns the line to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            bytes_q <= 2'd0;
            word_q  <= 32'h0000_0000;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            bytes_q <= bytes_d;
            word_q  <= word_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign UART_TX   = tx_q;
    assign bus.ready = ready_q;
    assign bus.done  = done_q;

endmodule
